seqdet_rr_sched: RTL and testbench

- Time-multiplexes one serial pattern-match engine across NCH independent serial bit channels.
- Default pattern is 11011, overlapping detection.
- Each channel has a 1-deep input holding register.
- A round-robin scheduler grants one channel per cycle. The engine loads that channel's saved history, evaluates the match, and writes the updated history back.
- Sits between per-lane serial receivers and downstream event logic; replaces NCH dedicated detector FSMs.

---
 rtl/seqdet_rr_sched.sv | 106 ++++++++++
 tb/tb_seqdet_rr_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seqdet_rr_sched.sv
// Shared serial pattern detector: one match engine time-multiplexed across NCH bit channels
// by a round-robin arbiter, with per-channel history saved between grants.
module seqdet_rr_sched #(
    parameter int                 NCH     = 4,
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b11011,
    localparam int                CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] in_valid,
    input  logic [NCH-1:0] in_bit,
    output logic [NCH-1:0] in_ready,
    input  logic [NCH-1:0] flush,
    output logic           match_valid,
    output logic [CW-1:0]  match_ch,
    output logic [CW-1:0]  grant_ch,
    output logic           grant_valid
);
    localparam int LW = $clog2(PAT_LEN + 1);

    logic [NCH-1:0]     full;
    logic [NCH-1:0]     hold;
    logic [PAT_LEN-1:0] hist [NCH];
    logic [LW-1:0]      len  [NCH];
    logic [CW-1:0]      ptr;

    logic               arb_found;
    logic [CW-1:0]      arb_ch;
    logic [PAT_LEN-1:0] win;
    logic               hit;

    // Scan downward from the farthest offset so the closest full channel at/after ptr wins.
    always_comb begin
        int            idx;
        logic [CW-1:0] cidx;
        arb_found = 1'b0;
        arb_ch    = '0;
        idx       = 0;
        cidx      = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx  = (int'(ptr) + k) % NCH;
            cidx = CW'(idx);
            if (full[cidx]) begin
                arb_found = 1'b1;
                arb_ch    = cidx;
            end
        end
    end

    // A flush on the chosen channel kills the grant outright, so the pointer holds too.
    assign grant_valid = arb_found & ~rst & ~flush[arb_ch];
    assign grant_ch    = grant_valid ? arb_ch : '0;

    assign win = {hist[grant_ch][PAT_LEN-2:0], hold[grant_ch]};
    assign hit = grant_valid && (win == PATTERN) && (len[grant_ch] >= LW'(PAT_LEN - 1));

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = ~rst & ~flush[i] & (~full[i] | (grant_valid & (grant_ch == CW'(i))));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (in_valid[i] && in_ready[i]) begin
                hold[i] <= in_bit[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full        <= '0;
            ptr         <= '0;
            match_valid <= 1'b0;
            match_ch    <= '0;
            for (int i = 0; i < NCH; i++) begin
                hist[i] <= '0;
                len[i]  <= '0;
            end
        end else begin
            match_valid <= hit;
            match_ch    <= hit ? grant_ch : '0;
            if (grant_valid) begin
                hist[grant_ch] <= win;
                if (len[grant_ch] != LW'(PAT_LEN)) begin
                    len[grant_ch] <= len[grant_ch] + 1'b1;
                end
                full[grant_ch] <= 1'b0;
                ptr            <= (grant_ch == CW'(NCH - 1)) ? '0 : grant_ch + 1'b1;
            end
            // Later assignments win: refill beats the grant's clear, flush beats both.
            for (int i = 0; i < NCH; i++) begin
                if (flush[i]) begin
                    hist[i] <= '0;
                    len[i]  <= '0;
                    full[i] <= 1'b0;
                end else if (in_valid[i] && in_ready[i]) begin
                    full[i] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seqdet_rr_sched.sv
// Bench for seqdet_rr_sched: per-channel bit queues drive the DUT, a reference detector
// predicts matches per channel, and observed matches retire those predictions.
module tb_seqdet_rr_sched;
    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] in_valid;
    logic [NCH-1:0] in_bit;
    logic [NCH-1:0] in_ready;
    logic [NCH-1:0] flush;
    logic           match_valid;
    logic [1:0]     match_ch;
    logic [1:0]     grant_ch;
    logic           grant_valid;

    seqdet_rr_sched #(.NCH(NCH), .PAT_LEN(5), .PATTERN(5'b11011)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .flush(flush), .match_valid(match_valid), .match_ch(match_ch),
        .grant_ch(grant_ch), .grant_valid(grant_valid)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    bit   sq [NCH][$];
    bit   [4:0] mh [NCH];
    int   ml   [NCH];
    int   pend [NCH];
    int   mcnt [NCH];
    int   sb_bad  = 0;
    int   lat_bad = 0;
    int   gq [$];
    int   mq [$];
    logic       pgv  = 1'b0;
    logic [1:0] pgch = 2'd0;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference detector updated on each accepted bit; results retired by match pulses.
    always @(negedge clk) begin
        if (match_valid) begin
            mq.push_back(int'(match_ch));
            mcnt[match_ch]++;
            if (pend[match_ch] == 0) sb_bad++;
            else pend[match_ch]--;
            if (!(pgv && pgch == match_ch)) lat_bad++;
        end
        if (grant_valid) gq.push_back(int'(grant_ch));
        pgv  = grant_valid;
        pgch = grant_ch;
        for (int c = 0; c < NCH; c++) begin
            if (rst || flush[c]) begin
                mh[c] = 5'd0;
                ml[c] = 0;
                if (rst) pend[c] = 0;
            end else if (in_valid[c] && in_ready[c]) begin
                mh[c] = {mh[c][3:0], in_bit[c]};
                if (ml[c] < 5) ml[c]++;
                if (mh[c] == 5'b11011 && ml[c] >= 5) pend[c]++;
            end
        end
    end

    function automatic bit any_pending();
        any_pending = 1'b0;
        for (int c = 0; c < NCH; c++) if (sq[c].size() > 0) any_pending = 1'b1;
    endfunction

    task automatic push_bits(input int c, input logic [7:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) sq[c].push_back(v[k]);
    endtask

    task automatic step(input int mode, input int k);
        bit all_busy;
        @(posedge clk); #1;
        all_busy = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            in_valid[c] = (sq[c].size() > 0);
            in_bit[c]   = (sq[c].size() > 0) ? sq[c][0] : 1'b0;
            if (sq[c].size() == 0) all_busy = 1'b0;
        end
        @(negedge clk);
        if (mode == 1 && in_valid[0]) check("t1_ready0", int'(in_ready[0]), 1);
        if (mode == 3 && k >= 1 && all_busy) check("t3_one_ready", $countones(in_ready), 1);
        for (int c = 0; c < NCH; c++) begin
            if (in_valid[c] && in_ready[c]) void'(sq[c].pop_front());
        end
    endtask

    task automatic run(input int mode, input int maxc);
        int k;
        k = 0;
        while (any_pending() && k < maxc) begin
            step(mode, k);
            k++;
        end
        if (any_pending()) check("stream_timeout", 1, 0);
        for (int c = 0; c < NCH; c++) sq[c].delete();
        repeat (8) step(0, 0);
    endtask

    task automatic do_flush(input logic [NCH-1:0] mask);
        @(posedge clk); #1;
        flush    = mask;
        in_valid = '0;
        @(negedge clk);
        check("flush_ready", int'(in_ready & mask), 0);
        @(posedge clk); #1;
        flush = '0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = '0;
        @(negedge clk);
        check("rst_ready", int'(in_ready), 0);
        check("rst_grant_valid", int'(grant_valid), 0);
        @(posedge clk); #1;
        check("rst_match_valid", int'(match_valid), 0);
        check("rst_match_ch", int'(match_ch), 0);
        check("rst_grant_ch", int'(grant_ch), 0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m0, m1, g0, q0, pend_sum;
        rst      = 1'b1;
        in_valid = '0;
        in_bit   = '0;
        flush    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", int'(in_ready), 0);
        check("reset_match_valid", int'(match_valid), 0);
        check("reset_match_ch", int'(match_ch), 0);
        check("reset_grant_valid", int'(grant_valid), 0);
        check("reset_grant_ch", int'(grant_ch), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single channel, back-to-back bits
        m0 = mcnt[0];
        push_bits(0, 8'b11011, 5);
        run(1, 40);
        check("t1_ch0_matches", mcnt[0] - m0, 1);
        check("t1_latency", lat_bad, 0);

        // overlapping matches, then a leading-1 run after flush
        m0 = mcnt[2];
        push_bits(2, 8'b11011011, 8);
        run(0, 40);
        check("t2_overlap_matches", mcnt[2] - m0, 2);
        do_flush(4'b0100);
        m0 = mcnt[2];
        push_bits(2, 8'b111011, 6);
        run(0, 40);
        check("t2_111011_matches", mcnt[2] - m0, 1);

        // all channels saturated: rotation order and match order
        pulse_rst();
        g0 = gq.size();
        q0 = mq.size();
        for (int c = 0; c < NCH; c++) push_bits(c, 8'b11011, 5);
        run(3, 80);
        for (int k = 0; k < 8; k++) check("t3_grant_order", gq[g0 + k], k % 4);
        check("t3_match_total", mq.size() - q0, 4);
        for (int k = 0; k < 4; k++) check("t3_match_order", (mq.size() > q0 + k) ? mq[q0 + k] : -1, k);

        // flush mid-pattern
        m0 = mcnt[1];
        push_bits(1, 8'b1101, 4);
        run(0, 40);
        do_flush(4'b0010);
        push_bits(1, 8'b1, 1);
        run(0, 40);
        check("t4_after_flush_1", mcnt[1] - m0, 0);
        push_bits(1, 8'b1011, 4);
        run(0, 40);
        check("t4_fresh_match", mcnt[1] - m0, 1);

        // interleaved channels keep independent history
        pulse_rst();
        m0 = mcnt[0];
        m1 = mcnt[3];
        push_bits(0, 8'b11011, 5);
        push_bits(3, 8'b11, 2);
        run(0, 40);
        check("t5_ch0_matches", mcnt[0] - m0, 1);
        check("t5_ch3_matches", mcnt[3] - m1, 0);

        // reset between 4th and 5th bit
        m0 = mcnt[0];
        push_bits(0, 8'b1101, 4);
        run(0, 40);
        pulse_rst();
        push_bits(0, 8'b1, 1);
        run(0, 40);
        check("t6_no_match_after_rst", mcnt[0] - m0, 0);
        push_bits(0, 8'b11011, 5);
        run(0, 40);
        check("t6_full_pattern", mcnt[0] - m0, 1);

        pend_sum = 0;
        for (int c = 0; c < NCH; c++) pend_sum += pend[c];
        check("sb_missing_matches", pend_sum, 0);
        check("sb_unexpected_matches", sb_bad, 0);
        check("match_latency", lat_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
